cycle_sequencer: RTL and testbench

//  Fetch/execute FSM in front of the combinational `control` decoder.
//  - Holds the instruction register and drives the decoder's `inst` and `cycle` inputs.
//  - Stretches memory-class instructions (inst[7]=1) over two cycles, handshaking with memory.
//  - Takes interrupts on instruction boundaries.
//  - Sits between the memory bus, the PC and `control`.

---
 rtl/cycle_sequencer.sv | 157 +++++++++++++++
 tb/tb_cycle_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// Fetch/execute sequencer that owns the instruction register and feeds the control decoder.
// Latency: non-memory instruction 2 clocks, memory-class instruction 3 clocks (zero-wait memory).
// Backpressure: mem_ready stalls FETCH and the EXEC0 data cycle; a stall reaching WAIT_LIMIT parks the FSM in FAULT.
module cycle_sequencer #(
  parameter logic [7:0]  RESET_INST = 8'h00,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic       irq,
  input  logic       cli,
  input  logic       sei,
  output logic [7:0] inst,
  output logic       cycle,
  output logic       fetch_req,
  output logic       data_req,
  output logic       exec_en,
  output logic       pc_inc,
  output logic       irq_ack,
  output logic       int_en,
  output logic       fault
);

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC0 = 3'd1;
  localparam logic [2:0] ST_EXEC1 = 3'd2;
  localparam logic [2:0] ST_IRQ   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Counter is 8 bits wide; WAIT_LIMIT is restricted to 1..255 so it always fits.
  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  logic [2:0] state;
  logic [2:0] nextState;
  logic [7:0] waitCnt;
  logic [7:0] nextWaitCnt;
  logic [7:0] instReg;
  logic       cycleReg;
  logic       intEnReg;

  logic       isMemInst;
  logic       waitHit;
  logic       takeIrq;
  logic       execCommit;
  logic       live;

  assign isMemInst = instReg[7];
  // The wait that is about to be counted would reach the limit.
  assign waitHit   = (waitCnt + 8'd1) == WAIT_MAX;
  // Interrupt is only honoured if the committing instruction is not itself a CLI.
  assign takeIrq   = irq & intEnReg & ~cli;
  // Register/flag commit happens on the last execute cycle of every instruction.
  assign execCommit = ((state == ST_EXEC0) && !isMemInst) || (state == ST_EXEC1);
  // While reset is held every strobe is forced low, even though state already reads FETCH.
  assign live = ~rst;

  // Next-state and wait-counter update; leaving a state always clears the counter.
  always_comb begin
    nextState   = state;
    nextWaitCnt = 8'd0;
    case (state)
      ST_FETCH: begin
        if (mem_ready) begin
          nextState = ST_EXEC0;
        end else if (waitHit) begin
          nextState = ST_FAULT;
        end else begin
          nextWaitCnt = waitCnt + 8'd1;
        end
      end
      ST_EXEC0: begin
        if (!isMemInst) begin
          nextState = takeIrq ? ST_IRQ : ST_FETCH;
        end else if (mem_ready) begin
          nextState = ST_EXEC1;
        end else if (waitHit) begin
          nextState = ST_FAULT;
        end else begin
          nextWaitCnt = waitCnt + 8'd1;
        end
      end
      ST_EXEC1: begin
        nextState = takeIrq ? ST_IRQ : ST_FETCH;
      end
      ST_IRQ: begin
        nextState = ST_FETCH;
      end
      ST_FAULT: begin
        nextState = ST_FAULT;
      end
      default: begin
        nextState = ST_FETCH;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      waitCnt <= 8'd0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
    end
  end

  // Instruction register loads only when a fetch completes; held through IRQ and FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instReg <= RESET_INST;
    end else if ((state == ST_FETCH) && mem_ready) begin
      instReg <= mem_rdata;
    end
  end

  // Second-cycle flag is high exactly while in EXEC1; frozen once faulted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleReg <= 1'b0;
    end else if (state != ST_FAULT) begin
      cycleReg <= (nextState == ST_EXEC1);
    end
  end

  // Interrupt-enable flag: IRQ entry clears it, otherwise commit cycles apply cli over sei.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intEnReg <= 1'b0;
    end else if (state == ST_IRQ) begin
      intEnReg <= 1'b0;
    end else if (execCommit) begin
      if (cli) begin
        intEnReg <= 1'b0;
      end else if (sei) begin
        intEnReg <= 1'b1;
      end
    end
  end

  // Moore decode of the strobes, with the two documented input qualifications.
  always_comb begin
    fetch_req = live & (state == ST_FETCH);
    data_req  = live & (state == ST_EXEC0) & isMemInst;
    exec_en   = live & execCommit;
    pc_inc    = live & (state == ST_FETCH) & mem_ready;
    irq_ack   = live & (state == ST_IRQ);
    fault     = live & (state == ST_FAULT);
  end

  assign inst   = instReg;
  assign cycle  = cycleReg;
  assign int_en = intEnReg;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Testbench for cycle_sequencer: directed scenarios plus randomized instruction stream.
// Expected outputs come from an instruction-level model (phase lengths and int_en rules).
// Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
module tb_cycle_sequencer;

  localparam logic [7:0] RESET_INST = 8'h00;
  localparam int         WAIT_LIMIT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic       irq = 1'b0;
  logic       cli = 1'b0;
  logic       sei = 1'b0;
  logic [7:0] inst;
  logic       cycle;
  logic       fetch_req;
  logic       data_req;
  logic       exec_en;
  logic       pc_inc;
  logic       irq_ack;
  logic       int_en;
  logic       fault;

  int checks = 0;
  int errors = 0;

  // Architectural model state.
  logic [7:0] mInst;
  logic       mIntEn;

  cycle_sequencer #(
    .RESET_INST(RESET_INST),
    .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .irq(irq),
    .cli(cli),
    .sei(sei),
    .inst(inst),
    .cycle(cycle),
    .fetch_req(fetch_req),
    .data_req(data_req),
    .exec_en(exec_en),
    .pc_inc(pc_inc),
    .irq_ack(irq_ack),
    .int_en(int_en),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected output vector {fetch,data,exec,pc,ack,fault,cycle,int_en,inst}.
  function automatic logic [15:0] ev(input bit f, input bit d, input bit e, input bit p,
                                     input bit a, input bit flt, input bit cy,
                                     input logic [7:0] in);
    return {f, d, e, p, a, flt, cy, mIntEn, in};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {fetch_req, data_req, exec_en, pc_inc, irq_ack, fault, cycle, int_en, inst};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs, advance to the next falling edge.
  task automatic cyc(input string tag, input bit rdy, input logic [7:0] rd,
                     input bit ir, input bit cl, input bit se, input logic [15:0] exp);
    mem_ready = rdy;
    mem_rdata = rd;
    irq       = ir;
    cli       = cl;
    sei       = se;
    #1;
    chk(tag, exp);
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    irq       = 1'b0;
    cli       = 1'b0;
    sei       = 1'b0;
    mInst     = RESET_INST;
    mIntEn    = 1'b0;
    #1;
    chk("reset_async", ev(0, 0, 0, 0, 0, 0, 0, RESET_INST));
    @(negedge clk);
    #1;
    chk("reset_held", ev(0, 0, 0, 0, 0, 0, 0, RESET_INST));
    rst = 1'b0;
  endtask

  // Whole instruction: fw fetch waits, dw data waits, boundary inputs bIrq/bCli/bSei.
  task automatic runInst(input string tag, input logic [7:0] op, input int fw, input int dw,
                         input bit bIrq, input bit bCli, input bit bSei);
    bit take;
    for (int i = 0; i < fw; i++)
      cyc({tag, "_fwait"}, 1'b0, 8'($urandom), rb(), rb(), rb(), ev(1, 0, 0, 0, 0, 0, 0, mInst));
    cyc({tag, "_fetch"}, 1'b1, op, rb(), rb(), rb(), ev(1, 0, 0, 1, 0, 0, 0, mInst));
    mInst = op;
    if (!op[7]) begin
      cyc({tag, "_exec0"}, rb(), 8'($urandom), bIrq, bCli, bSei, ev(0, 0, 1, 0, 0, 0, 0, op));
    end else begin
      for (int i = 0; i < dw; i++)
        cyc({tag, "_dwait"}, 1'b0, 8'($urandom), rb(), rb(), rb(), ev(0, 1, 0, 0, 0, 0, 0, op));
      cyc({tag, "_dready"}, 1'b1, 8'($urandom), rb(), rb(), rb(), ev(0, 1, 0, 0, 0, 0, 0, op));
      cyc({tag, "_exec1"}, rb(), 8'($urandom), bIrq, bCli, bSei, ev(0, 0, 1, 0, 0, 0, 1, op));
    end
    take   = bIrq & mIntEn & ~bCli;
    mIntEn = bCli ? 1'b0 : (bSei ? 1'b1 : mIntEn);
    if (take) begin
      cyc({tag, "_irq"}, rb(), 8'($urandom), rb(), rb(), rb(), ev(0, 0, 0, 0, 1, 0, 0, op));
      mIntEn = 1'b0;
    end
  endtask

  initial begin
    #2;
    applyReset();

    // Basic non-memory instruction, zero wait.
    runInst("nomem", 8'h41, 0, 0, 0, 0, 0);
    // Memory instruction with three data waits.
    runInst("mem3w", 8'h80, 0, 3, 0, 0, 0);
    // Enable interrupts, then memory instruction with irq at the boundary.
    runInst("seton", 8'h01, 1, 0, 0, 0, 1);
    runInst("irqmem", 8'h90, 0, 2, 1, 0, 0);
    runInst("afterirq", 8'h02, 0, 0, 0, 0, 0);
    // cli beats irq and sei at the boundary.
    runInst("seton2", 8'h03, 0, 0, 0, 0, 1);
    runInst("clibnd", 8'h04, 0, 0, 1, 1, 1);
    runInst("aftercli", 8'h05, 0, 0, 1, 0, 0);
    // Longest legal waits do not fault.
    runInst("maxwait", 8'hA5, WAIT_LIMIT - 1, WAIT_LIMIT - 1, 0, 0, 0);

    // Fetch timeout.
    applyReset();
    for (int i = 0; i < WAIT_LIMIT; i++)
      cyc("fault_wait", 1'b0, 8'($urandom), rb(), rb(), rb(), ev(1, 0, 0, 0, 0, 0, 0, mInst));
    for (int i = 0; i < 4; i++)
      cyc("fault_hold", rb(), 8'($urandom), rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 1, 0, mInst));
    applyReset();

    // Data-cycle timeout keeps the memory instruction in inst.
    runInst("dto_pre", 8'h07, 0, 0, 0, 0, 0);
    cyc("dto_fetch", 1'b1, 8'hC3, 0, 0, 0, ev(1, 0, 0, 1, 0, 0, 0, mInst));
    mInst = 8'hC3;
    for (int i = 0; i < WAIT_LIMIT; i++)
      cyc("dto_wait", 1'b0, 8'($urandom), rb(), rb(), rb(), ev(0, 1, 0, 0, 0, 0, 0, mInst));
    cyc("dto_fault", rb(), 8'($urandom), rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 1, 0, mInst));

    // Reset in the middle of an EXEC0 data wait.
    applyReset();
    cyc("mid_fetch", 1'b1, 8'h80, 0, 0, 0, ev(1, 0, 0, 1, 0, 0, 0, mInst));
    mInst = 8'h80;
    cyc("mid_dwait", 1'b0, 8'h00, 0, 0, 0, ev(0, 1, 0, 0, 0, 0, 0, mInst));
    mem_ready = 1'b0;
    #1;
    chk("mid_before_rst", ev(0, 1, 0, 0, 0, 0, 0, 8'h80));
    applyReset();

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      runInst("rand", 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              rb(), ($urandom_range(0, 3) == 0), rb());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
